// File: rtl/serial_addsub.sv
// serial_addsub
//   Digit-serial adder/subtractor. A WIDTH-bit operand pair is consumed DIGIT
//   bits per clock, least significant digit first, through a single
//   registered carry. Start-to-done latency is WIDTH/DIGIT + 1 edges.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset (synchronous release expected)
//   start      operation request
//   ready      idle, start will be accepted on the next rising edge
//   a, b       operands, sampled on the accepting edge
//   sub        0 = a + b + cin, 1 = a - b - cin; sampled on the accepting edge
//   cin        carry-in (add) or extra borrow (subtract)
//   done       one-cycle pulse, sum/cout/ovf hold the new result
//   sum        result register
//   cout       carry out of the MSB (for subtract: 1 = no borrow)
//   ovf        two's-complement signed overflow
//   dbg_state  current FSM state (0 = IDLE, 1 = RUN, 2 = DONE)
//
// Handshake: an operation is accepted on a rising edge where start=1 and
// ready=1. start while ready=0 is dropped, not queued. Holding start high
// accepts a new operation in every IDLE cycle. done is high for exactly one
// cycle per accepted operation that is not aborted by reset.
module serial_addsub #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             cin,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic [1:0]       dbg_state
);

  localparam int N  = (DIGIT > 0) ? (WIDTH / DIGIT) : 1;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  generate
    if (WIDTH < 1 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_params
      $fatal(1, "serial_addsub: WIDTH must be >= 1 and a multiple of DIGIT");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state, state_nx;

  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] psum;
  logic [WIDTH-1:0] psum_nx;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic [DIGIT:0]   dsum;
  logic             c_msb;
  logic             last;

  // One digit of addition per cycle; dsum[DIGIT] is the carry to the next digit.
  assign dsum = {1'b0, a_sr[DIGIT-1:0]} + {1'b0, b_sr[DIGIT-1:0]}
              + {{DIGIT{1'b0}}, carry};

  // Carry into the top bit of the current digit, recovered from the sum bit.
  // Only meaningful on the last digit, where it is the carry into the MSB.
  assign c_msb = dsum[DIGIT-1] ^ a_sr[DIGIT-1] ^ b_sr[DIGIT-1];

  // New digit enters at the MSB end; after N cycles the LSB digit has
  // migrated to bit 0. Written as a shift so DIGIT == WIDTH needs no special case.
  assign psum_nx = WIDTH'({dsum[DIGIT-1:0], psum} >> DIGIT);

  assign last = (cnt == CW'(N - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (start) state_nx = S_RUN;
      S_RUN:   if (last)  state_nx = S_DONE;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr  <= '0;
      b_sr  <= '0;
      psum  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            a_sr  <= a;
            // Subtract as a + ~b + 1; a borrow-in (cin=1) cancels the +1.
            b_sr  <= sub ? ~b : b;
            carry <= cin ^ sub;
            cnt   <= '0;
          end
        end
        S_RUN: begin
          a_sr  <= a_sr >> DIGIT;
          b_sr  <= b_sr >> DIGIT;
          psum  <= psum_nx;
          carry <= dsum[DIGIT];
          cnt   <= cnt + 1'b1;
          if (last) begin
            sum  <= psum_nx;
            cout <= dsum[DIGIT];
            ovf  <= c_msb ^ dsum[DIGIT];
          end
        end
        default: ;
      endcase
    end
  end

  assign ready     = (state == S_IDLE);
  assign done      = (state == S_DONE);
  assign dbg_state = state;

endmodule

// File: tb/tb_serial_addsub.sv
module tb_serial_addsub;

  localparam int W  = 16;
  localparam int N4 = 4;    // DIGIT=4
  localparam int N1 = 16;   // DIGIT=1
  localparam int NF = 1;    // DIGIT=16

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT signals ----------------
  logic [W-1:0] a = '0, b = '0;
  logic sub = 1'b0, cin = 1'b0;
  logic start4 = 1'b0, start1 = 1'b0, start16 = 1'b0;

  logic ready4, done4, cout4, ovf4;
  logic ready1, done1, cout1, ovf1;
  logic ready16, done16, cout16, ovf16;
  logic [W-1:0] sum4, sum1, sum16;
  logic [1:0] st4, st1, st16;

  serial_addsub #(.WIDTH(W), .DIGIT(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start4), .ready(ready4), .a(a), .b(b),
    .sub(sub), .cin(cin), .done(done4), .sum(sum4), .cout(cout4), .ovf(ovf4),
    .dbg_state(st4));

  serial_addsub #(.WIDTH(W), .DIGIT(1)) dut_d1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .ready(ready1), .a(a), .b(b),
    .sub(sub), .cin(cin), .done(done1), .sum(sum1), .cout(cout1), .ovf(ovf1),
    .dbg_state(st1));

  serial_addsub #(.WIDTH(W), .DIGIT(16)) dut_d16 (
    .clk(clk), .rst_n(rst_n), .start(start16), .ready(ready16), .a(a), .b(b),
    .sub(sub), .cin(cin), .done(done16), .sum(sum16), .cout(cout16), .ovf(ovf16),
    .dbg_state(st16));

  // ---------------- scoreboard state ----------------
  logic [W+1:0] exp_q[$];     // {cout, ovf, sum}
  int           exp_t_q[$];   // cycle count at which done must be seen
  int errors = 0;
  int checks = 0;
  bit held = 1'b0;
  int last_done = -1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Reference model: plain integer arithmetic on unsigned and signed values.
  function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic s, input logic c);
    longint ux, uy, sx, sy, lc, u, r;
    logic [W-1:0] res;
    logic co, ov;
    ux = longint'(x);
    uy = longint'(y);
    lc = c ? 64'sd1 : 64'sd0;
    sx = x[W-1] ? ux - (64'sd1 <<< W) : ux;
    sy = y[W-1] ? uy - (64'sd1 <<< W) : uy;
    if (!s) begin
      u  = ux + uy + lc;
      co = (u >= (64'sd1 <<< W));
      r  = sx + sy + lc;
    end else begin
      u  = ux - uy - lc;
      co = (u >= 0);          // no borrow
      r  = sx - sy - lc;
    end
    res = W'(u);
    ov  = (r > (64'sd1 <<< (W-1)) - 1) || (r < -(64'sd1 <<< (W-1)));
    return {co, ov, res};
  endfunction

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return '1;
      2:       return 16'h7FFF;
      3:       return 16'h8000;
      default: return W'($urandom_range(0, 16'hFFFF));
    endcase
  endfunction

  // Acceptance observer: an operation is taken on the next edge when start&ready.
  always @(negedge clk) begin
    if (rst_n && start4 && ready4) begin
      exp_q.push_back(model(a, b, sub, cin));
      exp_t_q.push_back(cyc + 1 + N4);
    end
  end

  // Result monitor for the DIGIT=4 instance.
  always @(negedge clk) begin
    if (done4) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 expected no pending op (t=%0t)", $time);
      end else begin
        logic [W+1:0] e;
        int t;
        e = exp_q.pop_front();
        t = exp_t_q.pop_front();
        check("sum",  32'(sum4),  32'(e[W-1:0]));
        check("cout", 32'(cout4), 32'(e[W+1]));
        check("ovf",  32'(ovf4),  32'(e[W]));
        check("done_cycle", 32'(cyc), 32'(t));
        if (held) begin
          if (last_done >= 0) check("b2b_spacing", 32'(cyc - last_done), 32'(N4 + 2));
          last_done = cyc;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic issue(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                       input logic ts, input logic tc);
    bit ok = 1'b0;
    @(posedge clk); #1;
    a = ta; b = tb_v; sub = ts; cin = tc; start4 = 1'b1;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (ready4) ok = 1'b1;
    end
    if (!ok) check("issue_timeout", 32'(ready4), 32'd1);
    @(posedge clk); #1;
    start4 = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && (exp_q.size() != 0 || !ready4); i++) @(negedge clk);
    check("drain_pending", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic run_alt(input bit wide, input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                         input logic ts, input logic tc);
    int n, acc;
    bit got;
    logic [W+1:0] e;
    n = wide ? NF : N1;
    e = model(ta, tb_v, ts, tc);
    @(posedge clk); #1;
    a = ta; b = tb_v; sub = ts; cin = tc;
    if (wide) start16 = 1'b1; else start1 = 1'b1;
    acc = cyc + 1;
    @(posedge clk); #1;
    start1 = 1'b0; start16 = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (wide ? done16 : done1) begin
        got = 1'b1;
        check(wide ? "d16_sum" : "d1_sum", 32'(wide ? sum16 : sum1), 32'(e[W-1:0]));
        check(wide ? "d16_cout" : "d1_cout", 32'(wide ? cout16 : cout1), 32'(e[W+1]));
        check(wide ? "d16_ovf" : "d1_ovf", 32'(wide ? ovf16 : ovf1), 32'(e[W]));
        check(wide ? "d16_latency" : "d1_latency", 32'(cyc - acc + 1), 32'(n + 1));
      end
    end
    if (!got) check(wide ? "d16_done_timeout" : "d1_done_timeout", 32'd0, 32'd1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    #3;
    check("rst_ready", 32'(ready4), 32'd1);
    check("rst_done",  32'(done4),  32'd0);
    check("rst_sum",   32'(sum4),   32'd0);
    check("rst_cout",  32'(cout4),  32'd0);
    check("rst_ovf",   32'(ovf4),   32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Basic add, then a start pulse during RUN that must be ignored.
    issue(16'h1234, 16'h0FFF, 1'b0, 1'b0);
    check("busy_ready", 32'(ready4), 32'd0);
    a = 16'hFFFF; b = 16'hFFFF; sub = 1'b1; cin = 1'b1; start4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0;
    drain();

    issue(16'hFFFF, 16'h0001, 1'b0, 1'b0); drain();
    issue(16'h7FFF, 16'h0001, 1'b0, 1'b0); drain();
    issue(16'h0005, 16'h0007, 1'b1, 1'b0); drain();
    issue(16'h0007, 16'h0005, 1'b1, 1'b1); drain();

    // Reset in the second RUN cycle aborts the operation.
    issue(16'hABCD, 16'h1111, 1'b0, 1'b1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    exp_t_q.delete();
    check("abort_ready", 32'(ready4), 32'd1);
    check("abort_done",  32'(done4),  32'd0);
    check("abort_sum",   32'(sum4),   32'd0);
    check("abort_cout",  32'(cout4),  32'd0);
    check("abort_ovf",   32'(ovf4),   32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (N4 + 3) @(posedge clk);
    #1;
    issue(16'h8000, 16'h8000, 1'b0, 1'b0); drain();

    // start held high: back-to-back operations.
    held = 1'b1;
    last_done = -1;
    @(posedge clk); #1;
    start4 = 1'b1;
    repeat (4 * (N4 + 2)) begin
      a = pick(); b = pick(); sub = 1'($urandom_range(0, 1)); cin = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    start4 = 1'b0;
    drain();
    held = 1'b0;

    // Random traffic, including start pulses while busy.
    repeat (300) begin
      start4 = ($urandom_range(0, 3) == 0);
      a = pick(); b = pick(); sub = 1'($urandom_range(0, 1)); cin = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    start4 = 1'b0;
    drain();

    // Other digit sizes.
    run_alt(1'b0, 16'h1234, 16'h0FFF, 1'b0, 1'b0);
    run_alt(1'b1, 16'h1234, 16'h0FFF, 1'b0, 1'b0);
    repeat (4) begin
      run_alt(1'b0, pick(), pick(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      run_alt(1'b1, pick(), pick(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    check("final_pending", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
